l2_snoop_responder: RTL
=======================

Name: l2_snoop_responder

Overview:
Bus-side responder for the L2 cache. It services snoops that other caches issue on the shared bus (READ, RFO, INVALIDATE, WRITE). For each snoop it looks up the tag/MESI store and flushes a Modified line when required. It then applies the MESI downgrade and drives the snoop result (NOHIT/HIT/HITM) back to the bus. It is the counterpart of the cache-side read-for-ownership initiator.

Parameters:
indexBits, 14, set index width
tagBits, 12, tag width
ways, 8, associativity; way fields are $clog2(ways) bits

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
snoop_valid  in  1  bus snoop request present
snoop_ready  out  1  responder idle, can accept
snoop_op  in  2  00 READ, 01 RFO, 10 INVALIDATE, 11 WRITE
snoop_own  in  1  snoop is this cache's own transaction
snoop_index  in  indexBits  snooped set
snoop_tag  in  tagBits  snooped tag
lkp_req  out  1  lookup request to tag store
lkp_index  out  indexBits  captured index
lkp_tag  out  tagBits  captured tag
lkp_ack  in  1  lookup result valid
lkp_hit  in  1  tag match with MESI != I
lkp_way  in  $clog2(ways)  matching way
lkp_mesi  in  2  I=00 S=01 E=10 M=11
wb_req  out  1  flush Modified line to bus
wb_index  out  indexBits  flush set
wb_way  out  $clog2(ways)  flush way
wb_done  in  1  flush complete
upd_valid  out  1  one-cycle MESI write strobe
upd_index  out  indexBits  set to update
upd_way  out  $clog2(ways)  way to update
upd_mesi  out  2  new MESI state
result_valid  out  1  one-cycle result strobe
snoop_result  out  2  00 NOHIT, 01 HIT, 10 HITM
proto_err  out  1  one-cycle pulse on illegal snoop/state combination
hitm_count  out  16  saturating count of HITM responses

Behaviour:
- Reset: FSM enters IDLE. snoop_ready=1. All other outputs are 0, including hitm_count. Reset mid-operation aborts immediately; no update or result is issued.
- FSM states: IDLE, LOOKUP, DECIDE, WRITEBACK, UPDATE, RESPOND.
- IDLE: snoop_ready=1 only in IDLE. On snoop_valid&&snoop_ready, capture op, index and tag.
  - If snoop_own=1, go to RESPOND with NOHIT; no lookup.
  - Otherwise go to LOOKUP.
- LOOKUP: hold lkp_req=1 with the captured index/tag until lkp_ack is sampled high. lkp_ack may arrive in the first LOOKUP cycle. On ack, register hit, way and mesi, then go to DECIDE.
- DECIDE, one cycle, rules by op (miss means hit=0):
  - READ: M → HITM, flush, then S. E or S → HIT, then S (no update when already S). Miss → NOHIT.
  - RFO: M → HITM, flush, then I. E or S → HIT, then I. Miss → NOHIT.
  - INVALIDATE: S → NOHIT, then I. E or M → proto_err, no change, NOHIT. Miss → NOHIT.
  - WRITE: any hit → proto_err, no change, NOHIT. Miss → NOHIT.
- DECIDE next state: WRITEBACK if a flush is needed; else UPDATE if the MESI state changes; else RESPOND.
- WRITEBACK: hold wb_req=1 until wb_done is sampled high, then go to UPDATE.
- UPDATE: upd_valid=1 for exactly one cycle, then go to RESPOND.
- RESPOND: result_valid=1 for one cycle with snoop_result, then return to IDLE.
  - hitm_count increments on each HITM response and saturates at 16'hFFFF.
- proto_err pulses in the DECIDE cycle.
- Minimum latency, handshake at T0 with same-cycle ack: T1 LOOKUP, T2 DECIDE, T3 UPDATE, T4 RESPOND. Without an update, RESPOND is at T3. For an own snoop, result_valid is at T1.
- Only one snoop is in flight; snoop_valid outside IDLE is ignored.
- Address outputs are stable while their req/strobe is high.

Test Plan:
- Reset asserted mid-WRITEBACK → all outputs 0 and snoop_ready=1 immediately; after release, a new snoop is accepted.
- READ, hit, lkp_mesi=M, way 3, index 0x12; wb_done after 4 cycles → wb_req held 4 cycles with wb_way=3; upd_mesi=S; snoop_result=HITM; hitm_count=1.
- RFO, hit, E, ack in same cycle → no wb_req; upd_mesi=I at T3; result HIT at T4.
- READ, hit, S → no upd_valid; result HIT at T3. Miss → NOHIT at T3.
- INVALIDATE hitting M, and WRITE hitting S → proto_err pulses once each; no upd_valid; result NOHIT.
- snoop_own=1 → no lkp_req; NOHIT at T1. Also 65536 HITM snoops (count preloaded by force) → hitm_count stays 16'hFFFF.

Source files
------------

// File: rtl/l2_snoop_responder_if.sv
// ----------------------------------------------------------------------------
// l2_snoop_responder_if : snoop, tag-lookup, flush, update and result signals
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface l2_snoop_responder_if #(
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12,
  parameter int WAYS       = 8
);
  localparam int WAY_BITS = $clog2(WAYS);

  logic                  snoop_valid;
  logic                  snoop_ready;
  logic [1:0]            snoop_op;
  logic                  snoop_own;
  logic [INDEX_BITS-1:0] snoop_index;
  logic [TAG_BITS-1:0]   snoop_tag;
  logic                  lkp_req;
  logic [INDEX_BITS-1:0] lkp_index;
  logic [TAG_BITS-1:0]   lkp_tag;
  logic                  lkp_ack;
  logic                  lkp_hit;
  logic [WAY_BITS-1:0]   lkp_way;
  logic [1:0]            lkp_mesi;
  logic                  wb_req;
  logic [INDEX_BITS-1:0] wb_index;
  logic [WAY_BITS-1:0]   wb_way;
  logic                  wb_done;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic [WAY_BITS-1:0]   upd_way;
  logic [1:0]            upd_mesi;
  logic                  result_valid;
  logic [1:0]            snoop_result;
  logic                  proto_err;
  logic [15:0]           hitm_count;

  modport master (
    output snoop_valid, snoop_op, snoop_own, snoop_index, snoop_tag,
    output lkp_ack, lkp_hit, lkp_way, lkp_mesi, wb_done,
    input  snoop_ready, lkp_req, lkp_index, lkp_tag, wb_req, wb_index, wb_way,
    input  upd_valid, upd_index, upd_way, upd_mesi,
    input  result_valid, snoop_result, proto_err, hitm_count
  );

  modport slave (
    input  snoop_valid, snoop_op, snoop_own, snoop_index, snoop_tag,
    input  lkp_ack, lkp_hit, lkp_way, lkp_mesi, wb_done,
    output snoop_ready, lkp_req, lkp_index, lkp_tag, wb_req, wb_index, wb_way,
    output upd_valid, upd_index, upd_way, upd_mesi,
    output result_valid, snoop_result, proto_err, hitm_count
  );
endinterface

`default_nettype wire

// File: rtl/l2_snoop_responder.sv
// ----------------------------------------------------------------------------
// l2_snoop_responder : services bus snoops with lookup, flush, MESI downgrade
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module l2_snoop_responder #(
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12,
  parameter int WAYS       = 8
) (
  input wire logic            clk,
  input wire logic            rst_n,
  l2_snoop_responder_if.slave bus
);
  localparam int WAY_BITS = $clog2(WAYS);

  localparam logic [1:0] c_OP_READ   = 2'b00;
  localparam logic [1:0] c_OP_RFO    = 2'b01;
  localparam logic [1:0] c_OP_INV    = 2'b10;
  localparam logic [1:0] c_MESI_S    = 2'b01;
  localparam logic [1:0] c_MESI_E    = 2'b10;
  localparam logic [1:0] c_MESI_M    = 2'b11;
  localparam logic [1:0] c_MESI_I    = 2'b00;
  localparam logic [1:0] c_RES_NOHIT = 2'b00;
  localparam logic [1:0] c_RES_HIT   = 2'b01;
  localparam logic [1:0] c_RES_HITM  = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    DECIDE    = 3'd2,
    WRITEBACK = 3'd3,
    UPDATE    = 3'd4,
    RESPOND   = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [1:0]            r_op;
  logic [INDEX_BITS-1:0] r_index;
  logic [TAG_BITS-1:0]   r_tag;
  logic                  r_hit;
  logic [WAY_BITS-1:0]   r_way;
  logic [1:0]            r_mesi;
  logic [15:0]           r_hitmCount;

  logic [1:0]            w_result;
  logic                  w_flush;
  logic [1:0]            w_newMesi;
  logic                  w_err;
  logic                  w_change;

  // Decision is a pure function of the captured lookup, so it stays valid
  // from DECIDE through RESPOND; own snoops clear r_hit and fall to NOHIT.
  always_comb begin
    w_result  = c_RES_NOHIT;
    w_flush   = 1'b0;
    w_newMesi = r_mesi;
    w_err     = 1'b0;
    if (r_hit) begin
      case (r_op)
        c_OP_READ, c_OP_RFO: begin
          if (r_mesi == c_MESI_M) begin
            w_result  = c_RES_HITM;
            w_flush   = 1'b1;
            w_newMesi = (r_op == c_OP_READ) ? c_MESI_S : c_MESI_I;
          end else if (r_mesi == c_MESI_E || r_mesi == c_MESI_S) begin
            w_result  = c_RES_HIT;
            w_newMesi = (r_op == c_OP_READ) ? c_MESI_S : c_MESI_I;
          end
        end
        c_OP_INV: begin
          if (r_mesi == c_MESI_S) begin
            w_newMesi = c_MESI_I;
          end else if (r_mesi == c_MESI_E || r_mesi == c_MESI_M) begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  assign w_change = (w_newMesi != r_mesi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState      = r_state;
    bus.snoop_ready  = 1'b0;
    bus.lkp_req      = 1'b0;
    bus.wb_req       = 1'b0;
    bus.upd_valid    = 1'b0;
    bus.upd_mesi     = c_MESI_I;
    bus.result_valid = 1'b0;
    bus.snoop_result = c_RES_NOHIT;
    bus.proto_err    = 1'b0;
    case (r_state)
      IDLE: begin
        bus.snoop_ready = 1'b1;
        if (bus.snoop_valid) begin
          w_nextState = bus.snoop_own ? RESPOND : LOOKUP;
        end
      end
      LOOKUP: begin
        bus.lkp_req = 1'b1;
        if (bus.lkp_ack) w_nextState = DECIDE;
      end
      DECIDE: begin
        bus.proto_err = w_err;
        if (w_flush)       w_nextState = WRITEBACK;
        else if (w_change) w_nextState = UPDATE;
        else               w_nextState = RESPOND;
      end
      WRITEBACK: begin
        bus.wb_req = 1'b1;
        if (bus.wb_done) w_nextState = UPDATE;
      end
      UPDATE: begin
        bus.upd_valid = 1'b1;
        bus.upd_mesi  = w_newMesi;
        w_nextState   = RESPOND;
      end
      RESPOND: begin
        bus.result_valid = 1'b1;
        bus.snoop_result = w_result;
        w_nextState      = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 2'b00;
      r_index     <= '0;
      r_tag       <= '0;
      r_hit       <= 1'b0;
      r_way       <= '0;
      r_mesi      <= c_MESI_I;
      r_hitmCount <= 16'h0000;
    end else begin
      if (r_state == IDLE && bus.snoop_valid) begin
        r_op    <= bus.snoop_op;
        r_index <= bus.snoop_index;
        r_tag   <= bus.snoop_tag;
        if (bus.snoop_own) begin
          r_hit  <= 1'b0;
          r_mesi <= c_MESI_I;
        end
      end
      if (r_state == LOOKUP && bus.lkp_ack) begin
        r_hit  <= bus.lkp_hit;
        r_way  <= bus.lkp_way;
        r_mesi <= bus.lkp_mesi;
      end
      if (r_state == RESPOND && w_result == c_RES_HITM && r_hitmCount != 16'hFFFF) begin
        r_hitmCount <= r_hitmCount + 16'd1;
      end
    end
  end

  assign bus.lkp_index  = r_index;
  assign bus.lkp_tag    = r_tag;
  assign bus.wb_index   = r_index;
  assign bus.wb_way     = r_way;
  assign bus.upd_index  = r_index;
  assign bus.upd_way    = r_way;
  assign bus.hitm_count = r_hitmCount;

endmodule

`default_nettype wire
